// File: rtl/direction_input_conditioner.sv
// direction_input_conditioner
// Conditions four raw, bouncy push-buttons into clean one-clock direction
// pulses (N/S/E/W) for the room FSM. Each button passes a 2-flop
// synchronizer and a per-button stable-count debouncer. A small FSM on the
// debounced vector then emits at most one direction per press, and never
// two directions in the same cycle.
// Optional feature: define DIR_REPEAT_EN to re-pulse a held direction every
// RPT_CYCLES clocks. The default build (macro undefined) has no repeat logic.
module direction_input_conditioner #(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned DB_W       = 16,
    parameter int unsigned RPT_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic BTN_N,
    input  logic BTN_S,
    input  logic BTN_E,
    input  logic BTN_W,
    output logic N,
    output logic S,
    output logic E,
    output logic W,
    output logic conflict,
    output logic busy
);

    localparam int unsigned NB = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    // Elaboration-time guard on parameter ranges
    if (DB_CYCLES == 0 || (DB_CYCLES >> DB_W) != 0 || RPT_CYCLES == 0) begin : g_bad_param
        $error("direction_input_conditioner: bad DB_CYCLES/DB_W/RPT_CYCLES");
    end

    // Bit order everywhere: [3]=N, [2]=S, [1]=E, [0]=W
    logic [NB-1:0]   raw;
    logic [NB-1:0]   sync1;
    logic [NB-1:0]   sync2;
    logic [NB-1:0]   db;
    logic [DB_W-1:0] db_cnt [NB];
    logic            db_one;

    state_t          state;
    state_t          state_next;
    logic [NB-1:0]   dir_next;
    logic            conflict_next;

    assign raw    = {BTN_N, BTN_S, BTN_E, BTN_W};
    assign db_one = (db != '0) && ((db & (db - 4'd1)) == '0);

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: accept a new level after DB_CYCLES differing cycles in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef DIR_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(RPT_CYCLES + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_next;
    logic [NB-1:0]    held_dir;
    logic [NB-1:0]    held_next;

    // Repeat counter and the direction that was accepted on entry to HELD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt  <= '0;
            held_dir <= '0;
        end else begin
            rpt_cnt  <= rpt_next;
            held_dir <= held_next;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output decode; a pulse is only ever issued out of IDLE (or repeat)
    always_comb begin
        state_next    = state;
        dir_next      = '0;
        conflict_next = 1'b0;
`ifdef DIR_REPEAT_EN
        rpt_next      = rpt_cnt;
        held_next     = held_dir;
`endif
        case (state)
            IDLE: begin
                if (db_one) begin
                    dir_next   = db;
                    state_next = HELD;
`ifdef DIR_REPEAT_EN
                    held_next  = db;
                    rpt_next   = '0;
`endif
                end else if (db != '0) begin
                    conflict_next = 1'b1;
                    state_next    = LOCKOUT;
                end
            end
            HELD: begin
                if (db == '0) begin
                    state_next = IDLE;
`ifdef DIR_REPEAT_EN
                    rpt_next   = '0;
                end else if (db == held_dir) begin
                    if (rpt_cnt == RPT_W'(RPT_CYCLES - 1)) begin
                        dir_next = held_dir;
                        rpt_next = '0;
                    end else begin
                        rpt_next = rpt_cnt + RPT_W'(1);
                    end
                end else begin
                    rpt_next = '0;
`endif
                end
            end
            LOCKOUT: begin
                if (db == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs; busy tracks the state the FSM is entering
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            N        <= 1'b0;
            S        <= 1'b0;
            E        <= 1'b0;
            W        <= 1'b0;
            conflict <= 1'b0;
            busy     <= 1'b0;
        end else begin
            {N, S, E, W} <= dir_next;
            conflict     <= conflict_next;
            busy         <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_direction_input_conditioner.sv
// Directed bench for direction_input_conditioner (DB_CYCLES=4, RPT_CYCLES=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A rise driven at the falling edge of cycle c is first sampled at edge c+1,
// so its direction pulse is seen at cycle c+1+2+4 = c+7.
module tb_direction_input_conditioner;

    localparam int unsigned DB  = 4;
    localparam int unsigned RPT = 32;
    localparam int          LAT = 3 + DB;

    logic clk = 1'b0;
    logic rst;
    logic btn_n, btn_s, btn_e, btn_w;
    logic n, s, e, w, conflict, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Pulse statistics gathered while stepping: index 3=N,2=S,1=E,0=W
    int pc [4];
    int pf [4];
    int cc;
    int cf;
    int multi = 0;
    int wq [$];

    direction_input_conditioner #(
        .DB_CYCLES (DB),
        .DB_W      (16),
        .RPT_CYCLES(RPT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .BTN_N   (btn_n),
        .BTN_S   (btn_s),
        .BTN_E   (btn_e),
        .BTN_W   (btn_w),
        .N       (n),
        .S       (s),
        .E       (e),
        .W       (w),
        .conflict(conflict),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            pc[i] = 0;
            pf[i] = -1;
        end
        cc = 0;
        cf = -1;
        wq.delete();
    endtask

    task automatic run(input int ncyc);
        logic [3:0] dv;
        repeat (ncyc) begin
            @(negedge clk);
            dv = {n, s, e, w};
            for (int i = 0; i < 4; i++) begin
                if (dv[i]) begin
                    pc[i]++;
                    if (pf[i] < 0) pf[i] = cyc;
                end
            end
            if (w) wq.push_back(cyc);
            if (conflict) begin
                cc++;
                if (cf < 0) cf = cyc;
            end
            if ($countones({dv, conflict}) > 1) multi++;
        end
    endtask

    task automatic test_reset();
        int c1;
        rst = 1'b1;
        btn_n = 0; btn_s = 0; btn_e = 0; btn_w = 0;
        run(2);
        checks++;
        if ({n, s, e, w, conflict, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b exp 000000", {n, s, e, w, conflict, busy});
        end
        rst = 1'b0;
        run(3);
        // Reset in the middle of the S debounce
        clear_stats();
        btn_s = 1'b1;
        run(3);
        rst = 1'b1;
        #1;
        checks++;
        if ({n, s, e, w, conflict, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_db: got %b exp 000000", {n, s, e, w, conflict, busy});
        end
        run(2);
        rst = 1'b0;
        c1 = cyc;
        clear_stats();
        run(DB + 1);
        checks++;
        if (pc[2] !== 0) begin
            errors++;
            $display("FAIL reset_early_s: got %0d pulses exp 0", pc[2]);
        end
        run(10);
        checks++;
        if (pc[2] !== 1 || pf[2] !== c1 + LAT) begin
            errors++;
            $display("FAIL reset_redebounce_s: got cnt %0d at %0d exp 1 at %0d", pc[2], pf[2], c1 + LAT);
        end
        // Reset while a press is held clears busy at once
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_pre: got %b exp 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({n, s, e, w, conflict, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_held: got %b exp 000000", {n, s, e, w, conflict, busy});
        end
        btn_s = 1'b0;
        run(2);
        rst = 1'b0;
        clear_stats();
        run(12);
        checks++;
        if (pc[2] !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_release: got cnt %0d busy %b exp 0 0", pc[2], busy);
        end
    endtask

    task automatic test_clean_press();
        int c;
        clear_stats();
        c = cyc;
        btn_s = 1'b1;
        run(20);
        checks++;
        if (pc[2] !== 1 || pf[2] !== c + LAT) begin
            errors++;
            $display("FAIL clean_s: got cnt %0d at %0d exp 1 at %0d", pc[2], pf[2], c + LAT);
        end
        checks++;
        if (pc[3] + pc[1] + pc[0] + cc !== 0) begin
            errors++;
            $display("FAIL clean_others: got %0d exp 0", pc[3] + pc[1] + pc[0] + cc);
        end
        btn_s = 1'b0;
        run(LAT - 1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_busy_held: got %b exp 1", busy);
        end
        run(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_busy_release: got %b exp 0", busy);
        end
        run(5);
    endtask

    task automatic test_bounce();
        int c;
        clear_stats();
        c = cyc;
        for (int k = 0; k < 5; k++) begin
            btn_e = ~k[0];
            run(2);
        end
        btn_e = 1'b1;
        run(20);
        checks++;
        if (pc[1] !== 1 || pf[1] !== c + 8 + LAT) begin
            errors++;
            $display("FAIL bounce_e: got cnt %0d at %0d exp 1 at %0d", pc[1], pf[1], c + 8 + LAT);
        end
        btn_e = 1'b0;
        run(12);
    endtask

    task automatic test_conflict();
        int c;
        clear_stats();
        c = cyc;
        btn_n = 1'b1;
        btn_w = 1'b1;
        run(12);
        checks++;
        if (cc !== 1 || cf !== c + LAT) begin
            errors++;
            $display("FAIL conflict_pulse: got cnt %0d at %0d exp 1 at %0d", cc, cf, c + LAT);
        end
        checks++;
        if (pc[3] !== 0 || pc[0] !== 0) begin
            errors++;
            $display("FAIL conflict_nodir: got N %0d W %0d exp 0 0", pc[3], pc[0]);
        end
        btn_w = 1'b0;
        run(12);
        checks++;
        if (pc[3] + pc[0] !== 0 || cc !== 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL conflict_lockout: got dir %0d conf %0d busy %b exp 0 1 1", pc[3] + pc[0], cc, busy);
        end
        btn_n = 1'b0;
        run(12);
        checks++;
        if (pc[3] + pc[0] !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL conflict_exit: got dir %0d busy %b exp 0 0", pc[3] + pc[0], busy);
        end
    endtask

    task automatic test_held_extra();
        int c;
        clear_stats();
        btn_s = 1'b1;
        run(10);
        btn_e = 1'b1;
        run(15);
        checks++;
        if (pc[2] !== 1 || pc[1] !== 0 || cc !== 0) begin
            errors++;
            $display("FAIL held_extra: got S %0d E %0d conf %0d exp 1 0 0", pc[2], pc[1], cc);
        end
        btn_s = 1'b0;
        btn_e = 1'b0;
        run(12);
        clear_stats();
        c = cyc;
        btn_e = 1'b1;
        run(12);
        checks++;
        if (pc[1] !== 1 || pf[1] !== c + LAT) begin
            errors++;
            $display("FAIL held_then_e: got cnt %0d at %0d exp 1 at %0d", pc[1], pf[1], c + LAT);
        end
        btn_e = 1'b0;
        run(12);
    endtask

    task automatic test_back_to_back();
        clear_stats();
        btn_s = 1'b1;
        run(12);
        // Release S and press E on the same edge: db never passes through zero
        btn_s = 1'b0;
        btn_e = 1'b1;
        run(20);
        checks++;
        if (pc[2] !== 1 || pc[1] !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL swap_no_e: got S %0d E %0d busy %b exp 1 0 1", pc[2], pc[1], busy);
        end
        btn_e = 1'b0;
        run(12);
        checks++;
        if (busy !== 1'b0 || pc[1] !== 0) begin
            errors++;
            $display("FAIL swap_exit: got busy %b E %0d exp 0 0", busy, pc[1]);
        end
    endtask

    task automatic test_repeat();
        int c;
        int a;
        clear_stats();
        c = cyc;
        a = c + LAT;
        btn_w = 1'b1;
        run(LAT + 100);
`ifdef DIR_REPEAT_EN
        checks++;
        if (wq.size() !== 4) begin
            errors++;
            $display("FAIL repeat_count: got %0d exp 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wq[i] !== a + i * int'(RPT)) begin
                    errors++;
                    $display("FAIL repeat_time%0d: got %0d exp %0d", i, wq[i], a + i * int'(RPT));
                end
            end
        end
`else
        checks++;
        if (pc[0] !== 1 || pf[0] !== a) begin
            errors++;
            $display("FAIL single_w: got cnt %0d at %0d exp 1 at %0d", pc[0], pf[0], a);
        end
`endif
        btn_w = 1'b0;
        run(12);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL repeat_exit_busy: got %b exp 0", busy);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (multi !== 0) begin
            errors++;
            $display("FAIL exclusive_outputs: got %0d multi-hot cycles exp 0", multi);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_clean_press();
        test_bounce();
        test_conflict();
        test_held_extra();
        test_back_to_back();
        test_repeat();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
